// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake on both sides and a shift-add multiplier.
// Define ALU_DIV_EN to add the restoring divider (DIVQ/DIVR); otherwise those opcodes decode as unused.
module alu_pipe #(
    parameter int width = 8,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    input  logic [OPW-1:0]   OpCode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] res,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             neg
);
    localparam int unsigned W  = width;
    localparam int unsigned CW = $clog2(W);

    localparam logic [OPW-1:0] OP_ADD   = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(1);
    localparam logic [OPW-1:0] OP_AND   = OPW'(2);
    localparam logic [OPW-1:0] OP_OR    = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR   = OPW'(4);
    localparam logic [OPW-1:0] OP_SHL   = OPW'(5);
    localparam logic [OPW-1:0] OP_SHR   = OPW'(6);
    localparam logic [OPW-1:0] OP_SLT   = OPW'(7);
    localparam logic [OPW-1:0] OP_MULLO = OPW'(8);
    localparam logic [OPW-1:0] OP_MULHI = OPW'(9);
    localparam logic [OPW-1:0] OP_ASR   = OPW'(10);
    localparam logic [OPW-1:0] OP_ROL   = OPW'(11);
`ifdef ALU_DIV_EN
    localparam logic [OPW-1:0] OP_DIVQ  = OPW'(12);
    localparam logic [OPW-1:0] OP_DIVR  = OPW'(13);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
`ifdef ALU_DIV_EN
        , DIV = 2'd3
`endif
    } state_t;

    state_t           state, state_d, start_st;
    logic [OPW-1:0]   op_q;
    logic [W-1:0]     opnd;
    logic [2*W-1:0]   acc, mul_next, step_next;
    logic [W:0]       mul_sum, sum_w, dif_w;
    logic [CW-1:0]    cnt;
    logic             accept, is_mul, is_div, busy, last;
    logic             ld, ld_c, ld_v;
    logic [W-1:0]     ld_res, alu_res;
    logic             alu_c, alu_v;
`ifdef ALU_DIV_EN
    logic [W:0]       rem_sh;
    logic [W+1:0]     div_dif;
    logic [2*W-1:0]   div_next;
`endif

    assign accept = in_valid && in_ready;
    assign is_mul = (OpCode == OP_MULLO) || (OpCode == OP_MULHI);
`ifdef ALU_DIV_EN
    assign is_div = (OpCode == OP_DIVQ) || (OpCode == OP_DIVR);
    assign busy   = (state == MUL) || (state == DIV);
`else
    assign is_div = 1'b0;
    assign busy   = (state == MUL);
`endif
    assign last = (cnt == CW'(W - 1));

    // Single-cycle operation decode
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        sum_w   = {1'b0, A} + {1'b0, B};
        dif_w   = {1'b0, A} - {1'b0, B};
        case (OpCode)
            OP_ADD: begin
                alu_res = sum_w[W-1:0];
                alu_c   = sum_w[W];
                alu_v   = ~(A[W-1] ^ B[W-1]) & (A[W-1] ^ sum_w[W-1]);
            end
            OP_SUB: begin
                alu_res = dif_w[W-1:0];
                alu_c   = dif_w[W];
                alu_v   = (A[W-1] ^ B[W-1]) & (A[W-1] ^ dif_w[W-1]);
            end
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_SHL:  alu_res = {A[W-2:0], 1'b0};
            OP_SHR:  alu_res = {1'b0, A[W-1:1]};
            OP_SLT:  alu_res = W'(A < B);
            OP_ASR:  alu_res = {A[W-1], A[W-1:1]};
            OP_ROL:  alu_res = {A[W-2:0], A[W-1]};
            default: alu_res = '0;
        endcase
    end

    // Multiplier in low half of acc; partial product accumulates in the high half and shifts right
    assign mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, acc[W-1:1]};

`ifdef ALU_DIV_EN
    // Remainder in high half, dividend shifts out of the low half as quotient bits shift in
    assign rem_sh   = {acc[2*W-1:W], acc[W-1]};
    assign div_dif  = {1'b0, rem_sh} - {2'b00, opnd};
    assign div_next = div_dif[W+1] ? {rem_sh[W-1:0], acc[W-2:0], 1'b0}
                                   : {div_dif[W-1:0], acc[W-2:0], 1'b1};
    assign step_next = (state == DIV) ? div_next : mul_next;
`else
    assign step_next = mul_next;
`endif

    always_comb begin
        start_st = DONE;
        if (is_mul) begin
            start_st = MUL;
        end
`ifdef ALU_DIV_EN
        else if (is_div) begin
            start_st = DIV;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (in_valid) state_d = start_st;
            MUL:     if (last) state_d = DONE;
`ifdef ALU_DIV_EN
            DIV:     if (last) state_d = DONE;
`endif
            DONE:    if (out_ready) state_d = in_valid ? start_st : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        out_valid = (state == DONE);
    end

    // Result load: either a single-cycle op at accept, or the final iterative step
    always_comb begin
        ld     = 1'b0;
        ld_res = '0;
        ld_c   = 1'b0;
        ld_v   = 1'b0;
        if (accept && !is_mul && !is_div) begin
            ld     = 1'b1;
            ld_res = alu_res;
            ld_c   = alu_c;
            ld_v   = alu_v;
        end else if ((state == MUL) && last) begin
            ld     = 1'b1;
            ld_res = (op_q == OP_MULHI) ? mul_next[2*W-1:W] : mul_next[W-1:0];
        end
`ifdef ALU_DIV_EN
        else if ((state == DIV) && last) begin
            ld     = 1'b1;
            ld_res = (op_q == OP_DIVR) ? div_next[2*W-1:W] : div_next[W-1:0];
            ld_v   = (opnd == '0);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= '0;
            opnd <= '0;
            acc  <= '0;
            cnt  <= '0;
        end else if (accept) begin
            op_q <= OpCode;
            opnd <= is_div ? B : A;
            acc  <= {W'(0), (is_div ? A : B)};
            cnt  <= '0;
        end else if (busy) begin
            acc  <= step_next;
            cnt  <= last ? '0 : cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res      <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            neg      <= 1'b0;
        end else if (ld) begin
            res      <= ld_res;
            zero     <= (ld_res == '0);
            carry    <= ld_c;
            overflow <= ld_v;
            neg      <= ld_res[W-1];
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at width=4; expectations are hand-computed vectors.
module tb_alu_pipe;
    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] OpCode;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] res;
    logic       zero;
    logic       carry;
    logic       overflow;
    logic       neg;

    typedef struct packed {
        logic [3:0] r;
        logic       z;
        logic       c;
        logic       v;
        logic       n;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    alu_pipe #(.width(4), .OPW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .OpCode    (OpCode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .neg       (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic exp_t mk(input logic [3:0] r, input logic z, input logic c,
                                input logic v, input logic n);
        exp_t e;
        e.r = r; e.z = z; e.c = c; e.v = v; e.n = n;
        return e;
    endfunction

    // Drive one operation and hold it until the DUT takes it
    task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         input exp_t e, input bit push);
        int n = 0;
        OpCode = op; A = a; B = b; in_valid = 1'b1;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Cycles from accept edge (counted as 1) until out_valid is seen
    task automatic wait_out(input int exp_lat, input string name);
        int lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk(name, lat, exp_lat);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("res", int'(res), int'(e.r));
                chk("flags_zcvn", int'({zero, carry, overflow, neg}), int'({e.z, e.c, e.v, e.n}));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; OpCode = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res", int'(res), 0);
        chk("rst_flags", int'({zero, carry, overflow, neg}), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;

        issue(4'd0, 4'd7, 4'd1, mk(4'd8, 0, 0, 1, 1), 1);   wait_out(1, "lat_add");
        issue(4'd1, 4'd3, 4'd5, mk(4'd14, 0, 1, 0, 1), 1);  wait_out(1, "lat_sub");
        issue(4'd1, 4'd8, 4'd1, mk(4'd7, 0, 0, 1, 0), 1);
        issue(4'd0, 4'd15, 4'd1, mk(4'd0, 1, 1, 0, 0), 1);
        issue(4'd2, 4'd12, 4'd10, mk(4'd8, 0, 0, 0, 1), 1);
        issue(4'd3, 4'd5, 4'd2, mk(4'd7, 0, 0, 0, 0), 1);
        issue(4'd5, 4'd9, 4'd0, mk(4'd2, 0, 0, 0, 0), 1);
        issue(4'd6, 4'd9, 4'd0, mk(4'd4, 0, 0, 0, 0), 1);
        issue(4'd7, 4'd3, 4'd5, mk(4'd1, 0, 0, 0, 0), 1);
        issue(4'd7, 4'd5, 4'd3, mk(4'd0, 1, 0, 0, 0), 1);
        issue(4'd10, 4'd9, 4'd0, mk(4'd12, 0, 0, 0, 1), 1);
        issue(4'd11, 4'd9, 4'd0, mk(4'd3, 0, 0, 0, 0), 1);
        issue(4'd14, 4'd5, 4'd5, mk(4'd0, 1, 0, 0, 0), 1); wait_out(1, "lat_unused");

        issue(4'd8, 4'd15, 4'd15, mk(4'd1, 0, 0, 0, 0), 1);
        chk("in_ready_in_mul", int'(in_ready), 0);
        wait_out(5, "lat_mullo");
        issue(4'd9, 4'd15, 4'd15, mk(4'd14, 0, 0, 0, 1), 1);
        wait_out(5, "lat_mulhi");

`ifdef ALU_DIV_EN
        issue(4'd12, 4'd13, 4'd4, mk(4'd3, 0, 0, 0, 0), 1);  wait_out(5, "lat_divq");
        issue(4'd13, 4'd13, 4'd4, mk(4'd1, 0, 0, 0, 0), 1);  wait_out(5, "lat_divr");
        issue(4'd12, 4'd9, 4'd0, mk(4'd15, 0, 0, 1, 1), 1);  wait_out(5, "lat_divq0");
        issue(4'd13, 4'd9, 4'd0, mk(4'd9, 0, 0, 1, 1), 1);   wait_out(5, "lat_divr0");
`else
        issue(4'd12, 4'd13, 4'd4, mk(4'd0, 1, 0, 0, 0), 1);  wait_out(1, "lat_divq_off");
`endif

        // Backpressure: first XOR held for 4 cycles while the next two wait
        @(posedge clk); #1;
        out_ready = 1'b0;
        fork
            begin
                issue(4'd4, 4'd6, 4'd3, mk(4'd5, 0, 0, 0, 0), 1);
                issue(4'd4, 4'd12, 4'd10, mk(4'd6, 0, 0, 0, 0), 1);
                issue(4'd4, 4'd15, 4'd1, mk(4'd14, 0, 0, 0, 1), 1);
            end
            begin
                @(posedge clk); #1;
                for (int i = 0; i < 4; i++) begin
                    chk("bp_valid_held", int'(out_valid), 1);
                    chk("bp_res_held", int'(res), 5);
                    chk("bp_in_ready", int'(in_ready), 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
                chk("bp_seq0", int'(res), 5);
                @(posedge clk); #1;
                chk("bp_seq1_valid", int'(out_valid), 1);
                chk("bp_seq1", int'(res), 6);
                @(posedge clk); #1;
                chk("bp_seq2_valid", int'(out_valid), 1);
                chk("bp_seq2", int'(res), 14);
            end
        join

        // Reset during the second multiply cycle
        issue(4'd8, 4'd3, 4'd3, mk(4'd9, 0, 0, 0, 0), 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_res", int'(res), 0);
        chk("abort_flags", int'({zero, carry, overflow, neg}), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        issue(4'd0, 4'd2, 4'd2, mk(4'd4, 0, 0, 0, 0), 1);
        wait_out(1, "lat_add_after_abort");

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's combinational ALU.
- Accepts one operation per handshake and returns a registered result plus flags.
- Keeps the 8 single-cycle ops and adds multi-cycle shift-add multiply (low/high product words).
- Sits between the operand-fetch stage and writeback, with valid/ready on both sides.

Parameters:
- width, 8, operand/result bit width (>=4).
- OPW, 4, opcode width (fixed at 4; parameter kept for decode tables).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands/opcode valid.
- in_ready  output  1  block can accept an operation this cycle.
- A  input  width  operand A.
- B  input  width  operand B.
- OpCode  input  OPW  operation select.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts result.
- res  output  width  result.
- zero  output  1  res == 0.
- carry  output  1  ADD carry-out; SUB borrow.
- overflow  output  1  signed overflow (ADD/SUB only).
- neg  output  1  res[width-1].

Behaviour:
- Reset (async assert, sync release): state=IDLE; res=0, all flags 0, out_valid=0, in_ready=1.
- Accept: in_valid && in_ready at a rising edge; A, B, OpCode captured.
- States: IDLE, MUL, DONE.
  - IDLE: accept; single-cycle op -> DONE; op 1000/1001 -> MUL.
  - MUL: runs exactly width cycles, one shift-add step per cycle, then -> DONE.
  - DONE: out_valid=1. On out_ready -> IDLE, or directly re-accept (see below).
- in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Single-cycle ops therefore sustain one result per cycle under continuous out_ready.
- Latency from accept edge to out_valid:
  - single-cycle ops: 1 cycle.
  - MUL: width+1 cycles.
- Result and flags hold stable while out_valid && !out_ready. No new operation is accepted while held.
- Opcodes (unsigned unless noted):
  - 0000 ADD: {carry,res}=A+B; overflow=~(A^B)msb & (A^res)msb.
  - 0001 SUB: {carry,res}=A-B, carry=1 when A<B; overflow=(A^B)msb & (A^res)msb.
  - 0010 AND; 0011 OR; 0100 XOR.
  - 0101 SHL: A<<1.
  - 0110 SHR: A>>1, logical.
  - 0111 SLT: res=(A<B) zero-extended.
  - 1000 MULLO: res=low width bits of A*B.
  - 1001 MULHI: res=high width bits of A*B.
  - 1010 ASR: arithmetic A>>>1.
  - 1011 ROL: rotate A left by 1.
  - Others: res=0, all flags computed from res=0 (zero=1).
- carry and overflow are 0 for all ops except ADD/SUB.
- zero and neg are derived from the final res for every op.
- Multiply: 2*width accumulator plus bit counter; counter wraps to 0 on exit. No early termination, even for B=0.
- in_valid while busy in MUL: ignored, in_ready=0.
- Reset asserted mid-MUL: aborts immediately, outputs return to reset values, partial product discarded.

Optional Feature:
- ALU_DIV_EN defined: adds 1100 DIVQ and 1101 DIVR, unsigned restoring division, state DIV, width cycles, latency width+1.
  - B=0: quotient all-ones, remainder=A, overflow=1.
  - carry=0.
- ALU_DIV_EN undefined: 1100/1101 decode as unused (res=0, zero=1, single-cycle). No divider logic synthesised.

Test Plan (width=4 unless noted):
- ADD A=7,B=1, out_ready=1 -> next cycle res=8, overflow=1, neg=1, carry=0, zero=0.
- SUB A=3,B=5 -> res=14, carry=1, neg=1, overflow=0. Then SUB A=8,B=1 -> res=7, overflow=1.
- MULLO 15*15 -> res=1 exactly 5 cycles after accept; in_ready=0 during MUL. MULHI 15*15 -> res=14, neg=1.
- Backpressure: 3 back-to-back XORs with out_ready=0 for 4 cycles -> first result held stable, in_ready=0, no op lost. After release, all 3 results appear in order on consecutive cycles.
- rst_n low on 2nd MUL cycle -> out_valid=0, res=0, flags 0, in_ready=1 immediately. Next ADD 2+2 -> res=4.
- ALU_DIV_EN: DIVQ 13/4 -> 3; DIVR 13/4 -> 1; DIVQ 9/0 -> 15 with overflow=1; DIVR 9/0 -> 9. Without macro: DIVQ -> res=0, zero=1 after 1 cycle.
